// File: rtl/sig_port_tap.sv
// Explicit-port capture tap: samples the AND child's pins {a, b, c} into a small
// first-word-fall-through FIFO drained over a valid/ready handshake.

module sig_port_tap_and2 (
    input  logic port_a,
    input  logic port_b,
    output logic port_c
);
    assign port_c = port_a & port_b;
endmodule

module sig_port_tap #(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          port_a,
    input  logic          port_b,
    input  logic          sample_en,
    input  logic          clear_ovf,
    input  logic          tap_ready,
    output logic          port_d,
    output logic          tap_valid,
    output logic [2:0]    tap_data,
    output logic [CW-1:0] count,
    output logic          overflow
);
    localparam int AW = $clog2(DEPTH);

    logic          child_c;
    logic [2:0]    sample_word;
    logic          push;
    logic          pop;
    logic          full;
    logic          drop;

    logic [2:0]    mem_q [DEPTH];
    logic [2:0]    mem_d [DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    sig_port_tap_and2 test (
        .port_a (port_a),
        .port_b (port_b),
        .port_c (child_c)
    );

    assign port_d      = child_c;
    assign sample_word = {port_a, port_b, child_c};

    assign tap_valid = (count_q != '0);
    assign tap_data  = mem_q[rp_q];
    assign count     = count_q;
    assign overflow  = overflow_q;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
    assign pop  = tap_valid & tap_ready;
    assign full = (count_q == CW'(DEPTH));
    assign push = sample_en & (~full | pop);
    assign drop = sample_en & full & ~pop;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        mem_d      = mem_q;
        wp_d       = wp_q;
        rp_d       = rp_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push) begin
            mem_d[wp_q] = sample_word;
            wp_d        = wp_q + AW'(1);
        end
        if (pop) begin
            rp_d = rp_q + AW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Set beats clear when both happen in one cycle.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the storage array is reset too, so tap_data reads a defined
            // 3'b000 straight out of reset instead of X.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wp_q       <= '0;
            rp_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge
            // values computed above, independent of statement order.
            mem_q      <= mem_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end
endmodule

// File: tb/tb_sig_port_tap.sv
// Directed bench for sig_port_tap: reset/port_d, single sample, fill/overflow,
// full-with-push-and-pop across pointer wrap, drop-vs-clear and mid-stream reset.

module tb_sig_port_tap;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          port_a;
    logic          port_b;
    logic          sample_en;
    logic          clear_ovf;
    logic          tap_ready;
    logic          port_d;
    logic          tap_valid;
    logic [2:0]    tap_data;
    logic [CW-1:0] count;
    logic          overflow;

    int n_vec = 0;
    int n_err = 0;

    logic [2:0] exp_q [$];

    sig_port_tap #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .port_a    (port_a),
        .port_b    (port_b),
        .sample_en (sample_en),
        .clear_ovf (clear_ovf),
        .tap_ready (tap_ready),
        .port_d    (port_d),
        .tap_valid (tap_valid),
        .tap_data  (tap_data),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] word(input logic a, input logic b);
        return {a, b, a & b};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] fill_exp [4];
        logic [1:0] ab;

        rst       = 1'b0;
        port_a    = 1'b0;
        port_b    = 1'b0;
        sample_en = 1'b0;
        clear_ovf = 1'b0;
        tap_ready = 1'b0;

        // Reset held: port_d follows a&b, FIFO state stays cleared.
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            port_a = ab[1];
            port_b = ab[0];
            #2;
            check("rst_port_d", 8'(port_d), 8'(ab[1] & ab[0]));
            check("rst_valid",  8'(tap_valid), 8'd0);
            check("rst_count",  8'(count), 8'd0);
            check("rst_ovf",    8'(overflow), 8'd0);
        end
        check("rst_data", 8'(tap_data), 8'd0);

        @(posedge clk);
        #1;
        rst = 1'b1;

        // Single sample, then pop.
        port_a = 1'b1; port_b = 1'b1; sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        check("single_valid", 8'(tap_valid), 8'd1);
        check("single_data",  8'(tap_data), 8'b111);
        check("single_count", 8'(count), 8'd1);
        tap_ready = 1'b1;
        tick();
        check("single_pop_valid", 8'(tap_valid), 8'd0);
        check("single_pop_count", 8'(count), 8'd0);
        tap_ready = 1'b0;

        // Fill with five words; the fifth is dropped.
        for (int i = 0; i < 5; i++) begin
            ab = 2'(i % 4);
            port_a = ab[1]; port_b = ab[0]; sample_en = 1'b1;
            tick();
            if (i == 3) begin
                check("fill_count4", 8'(count), 8'd4);
                check("fill_ovf_clear", 8'(overflow), 8'd0);
            end
        end
        sample_en = 1'b0;
        check("fill_count_after_drop", 8'(count), 8'd4);
        check("fill_ovf_set", 8'(overflow), 8'd1);

        fill_exp = '{3'b000, 3'b010, 3'b100, 3'b111};
        tap_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", 8'(tap_valid), 8'd1);
            check("drain_data",  8'(tap_data), 8'(fill_exp[i]));
            tick();
        end
        tap_ready = 1'b0;
        check("drain_empty", 8'(tap_valid), 8'd0);
        check("drain_ovf_sticky", 8'(overflow), 8'd1);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        check("clear_ovf", 8'(overflow), 8'd0);

        // Fill to DEPTH, then sustained push+pop across pointer wrap.
        for (int i = 0; i < 4; i++) begin
            ab = 2'(3 - i);
            port_a = ab[1]; port_b = ab[0]; sample_en = 1'b1;
            exp_q.push_back(word(ab[1], ab[0]));
            tick();
        end
        check("full_count", 8'(count), 8'd4);
        tap_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ab = 2'((i * 3 + 1) % 4);
            port_a = ab[1]; port_b = ab[0]; sample_en = 1'b1;
            #1;
            check("pp_data", 8'(tap_data), 8'(exp_q[0]));
            void'(exp_q.pop_front());
            exp_q.push_back(word(ab[1], ab[0]));
            tick();
            check("pp_count", 8'(count), 8'd4);
            check("pp_ovf",   8'(overflow), 8'd0);
        end
        tap_ready = 1'b0;
        sample_en = 1'b0;

        // Drop and clear_ovf together: set wins, contents unchanged.
        port_a = 1'b1; port_b = 1'b1; sample_en = 1'b1; clear_ovf = 1'b1;
        tick();
        sample_en = 1'b0; clear_ovf = 1'b0;
        check("prio_ovf",   8'(overflow), 8'd1);
        check("prio_count", 8'(count), 8'd4);
        check("prio_head",  8'(tap_data), 8'(exp_q[0]));

        // Pop one to reach count 3, then async reset between edges.
        tap_ready = 1'b1;
        tick();
        tap_ready = 1'b0;
        check("mid_count3", 8'(count), 8'd3);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_valid", 8'(tap_valid), 8'd0);
        check("mid_rst_count", 8'(count), 8'd0);
        check("mid_rst_ovf",   8'(overflow), 8'd0);
        rst = 1'b1;
        exp_q.delete();

        port_a = 1'b0; port_b = 1'b1; sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        check("post_rst_valid", 8'(tap_valid), 8'd1);
        check("post_rst_data",  8'(tap_data), 8'b010);
        check("post_rst_count", 8'(count), 8'd1);
        tap_ready = 1'b1;
        tick();
        tap_ready = 1'b0;
        check("post_rst_empty", 8'(tap_valid), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
